// File: rtl/pix2byte_gearbox.sv
// Pixel-to-byte-lane gearbox: packs PIX_WIDTH pixels into NUM_LANES-byte words, flushing a partial word at end of line.
// Latency 1 cycle from pixel accept to byte visibility; pix_ready depends only on fill level and flush state, never on byte_ready.
// Optional line byte counter (line_wc/wc_valid) is built when PIX2BYTE_WC_EN is defined.
`timescale 1ns/1ps
module pix2byte_gearbox #(
  parameter int NUM_LANES = 2,
  parameter int PIX_WIDTH = 24
) (
  input  logic                   CLKI,
  input  logic                   RST,
  input  logic [PIX_WIDTH-1:0]   pix_data,
  input  logic                   pix_valid,
  input  logic                   pix_last,
  output logic                   pix_ready,
  output logic [8*NUM_LANES-1:0] byte_data,
  output logic [NUM_LANES-1:0]   byte_keep,
  output logic                   byte_valid,
  output logic                   byte_last,
  input  logic                   byte_ready
`ifdef PIX2BYTE_WC_EN
  ,
  output logic [15:0]            line_wc,
  output logic                   wc_valid
`endif
);

  localparam int BPP = PIX_WIDTH / 8;
  localparam int CAP = 2 * (BPP + NUM_LANES);
  localparam int CW  = $clog2(CAP + 1);
  localparam logic [CW-1:0] LANES_C = CW'(NUM_LANES);
  localparam logic [CW-1:0] BPP_C   = CW'(BPP);
  localparam logic [CW-1:0] RDY_MAX = CW'(CAP - BPP);

  logic [7:0]    buf_q [CAP];
  logic [7:0]    buf_d [CAP];
  logic [7:0]    shift_src [CAP + NUM_LANES];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flush_q, flush_d;
  logic [CW-1:0] avail;
  logic [CW-1:0] pop;
  logic [CW-1:0] wr_base;
  logic          accept;
  logic          xfer;

  // Output side is decoded purely from registered state; RST only gates it to zero.
  always_comb begin
    avail      = (cnt_q < LANES_C) ? cnt_q : LANES_C;
    pix_ready  = !RST && (cnt_q <= RDY_MAX) && !flush_q;
    byte_valid = !RST && ((cnt_q >= LANES_C) || (flush_q && (cnt_q != '0)));
    byte_last  = byte_valid && flush_q && (cnt_q <= LANES_C);
    byte_data  = '0;
    byte_keep  = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (byte_valid && (CW'(k) < avail)) begin
        byte_data[8*k +: 8] = buf_q[k];
        byte_keep[k]        = 1'b1;
      end
    end
  end

  always_comb begin
    accept  = pix_valid && pix_ready;
    xfer    = byte_valid && byte_ready;
    pop     = xfer ? avail : '0;
    wr_base = cnt_q - pop;

    for (int j = 0; j < CAP; j++) begin
      shift_src[j] = buf_q[j];
    end
    for (int j = CAP; j < CAP + NUM_LANES; j++) begin
      shift_src[j] = 8'h00;
    end

    // Pop from the head first, then append the new pixel right behind the survivors.
    for (int i = 0; i < CAP; i++) begin
      buf_d[i] = 8'h00;
      for (int s = 0; s <= NUM_LANES; s++) begin
        if (pop == CW'(s)) begin
          buf_d[i] = shift_src[i + s];
        end
      end
      for (int b = 0; b < BPP; b++) begin
        if (accept && ((wr_base + CW'(b)) == CW'(i))) begin
          buf_d[i] = pix_data[8*b +: 8];
        end
      end
    end

    cnt_d = cnt_q - pop + (accept ? BPP_C : '0);

    flush_d = flush_q;
    if (accept && pix_last) begin
      flush_d = 1'b1;
    end else if (xfer && flush_q && (cnt_q <= LANES_C)) begin
      flush_d = 1'b0;
    end
  end

  always_ff @(posedge CLKI) begin
    if (RST) begin
      cnt_q   <= '0;
      flush_q <= 1'b0;
      for (int i = 0; i < CAP; i++) begin
        buf_q[i] <= 8'h00;
      end
    end else begin
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      for (int i = 0; i < CAP; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

`ifdef PIX2BYTE_WC_EN
  logic [15:0] wc_acc_q, wc_acc_d;
  logic [15:0] line_wc_q, line_wc_d;
  logic        wc_valid_q, wc_valid_d;

  // Counts bytes as they leave, so a reset mid-line never reports a partial count.
  always_comb begin
    wc_acc_d   = wc_acc_q + 16'(pop);
    line_wc_d  = line_wc_q;
    wc_valid_d = 1'b0;
    if (xfer && byte_last) begin
      line_wc_d  = wc_acc_q + 16'(pop);
      wc_acc_d   = '0;
      wc_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLKI) begin
    if (RST) begin
      wc_acc_q   <= '0;
      line_wc_q  <= '0;
      wc_valid_q <= 1'b0;
    end else begin
      wc_acc_q   <= wc_acc_d;
      line_wc_q  <= line_wc_d;
      wc_valid_q <= wc_valid_d;
    end
  end

  assign line_wc  = line_wc_q;
  assign wc_valid = wc_valid_q;
`endif

endmodule

// File: tb/tb_pix2byte_gearbox.sv
// Scoreboard bench for pix2byte_gearbox: default 2-lane RGB888 instance plus a 4-lane RGB565 instance.
`timescale 1ns/1ps
module tb_pix2byte_gearbox;

  logic        CLKI = 1'b0;
  logic        RST  = 1'b1;
  always #5 CLKI = ~CLKI;

  logic [23:0] pix_data = '0;
  logic        pix_valid = 1'b0, pix_last = 1'b0, pix_ready;
  logic [15:0] byte_data;
  logic [1:0]  byte_keep;
  logic        byte_valid, byte_last;
  logic        byte_ready = 1'b1;

  logic [15:0] p4_data = '0;
  logic        p4_valid = 1'b0, p4_last = 1'b0, p4_ready;
  logic [31:0] b4_data;
  logic [3:0]  b4_keep;
  logic        b4_valid, b4_last;
  logic        b4_ready = 1'b1;

`ifdef PIX2BYTE_WC_EN
  logic [15:0] line_wc, line_wc4;
  logic        wc_valid, wc_valid4;
`endif

  pix2byte_gearbox #(.NUM_LANES(2), .PIX_WIDTH(24)) u_dut (
    .CLKI(CLKI), .RST(RST),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_last(pix_last), .pix_ready(pix_ready),
    .byte_data(byte_data), .byte_keep(byte_keep), .byte_valid(byte_valid),
    .byte_last(byte_last), .byte_ready(byte_ready)
`ifdef PIX2BYTE_WC_EN
    , .line_wc(line_wc), .wc_valid(wc_valid)
`endif
  );

  pix2byte_gearbox #(.NUM_LANES(4), .PIX_WIDTH(16)) u_dut4 (
    .CLKI(CLKI), .RST(RST),
    .pix_data(p4_data), .pix_valid(p4_valid), .pix_last(p4_last), .pix_ready(p4_ready),
    .byte_data(b4_data), .byte_keep(b4_keep), .byte_valid(b4_valid),
    .byte_last(b4_last), .byte_ready(b4_ready)
`ifdef PIX2BYTE_WC_EN
    , .line_wc(line_wc4), .wc_valid(wc_valid4)
`endif
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  word_t sb[$];
  word_t sb4[$];
  int    wc_exp[$];
  int    wc_acc = 0;
  int    checks = 0;
  int    passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    checks++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  task automatic expect2(input logic [31:0] d, input logic [3:0] k, input logic l);
    sb.push_back('{data: d, keep: k, last: l});
    wc_acc += $countones(k);
    if (l) begin
      wc_exp.push_back(wc_acc);
      wc_acc = 0;
    end
  endtask

  // Monitors: compare every transfer against the scoreboard, and idle outputs against zero.
  always @(negedge CLKI) begin
    word_t e;
    if (byte_valid && byte_ready) begin
      if (sb.size() == 0) fail("unexpected_word");
      else begin
        e = sb.pop_front();
        check("word_data", 32'(byte_data), e.data);
        check("word_keep", 32'(byte_keep), 32'(e.keep));
        check("word_last", 32'(byte_last), 32'(e.last));
      end
    end else if (!byte_valid) begin
      check("idle_zero", 32'({byte_data, byte_keep, byte_last}), 32'h0);
    end
  end

  always @(negedge CLKI) begin
    word_t e;
    if (b4_valid && b4_ready) begin
      if (sb4.size() == 0) fail("unexpected_word4");
      else begin
        e = sb4.pop_front();
        check("word4_data", b4_data, e.data);
        check("word4_keep", 32'(b4_keep), 32'(e.keep));
        check("word4_last", 32'(b4_last), 32'(e.last));
      end
    end
  end

`ifdef PIX2BYTE_WC_EN
  always @(negedge CLKI) begin
    int w;
    if (wc_valid) begin
      if (wc_exp.size() == 0) fail("unexpected_wc_pulse");
      else begin
        w = wc_exp.pop_front();
        check("line_wc", 32'(line_wc), 32'(w));
      end
    end
  end
`endif

  task automatic send(input logic [23:0] d, input logic l);
    int n = 0;
    pix_data = d; pix_valid = 1'b1; pix_last = l;
    @(negedge CLKI);
    while (!pix_ready && n < 200) begin
      @(negedge CLKI);
      n++;
    end
    if (!pix_ready) fail("pix_accept_timeout");
    @(posedge CLKI);
    #1;
    pix_valid = 1'b0; pix_last = 1'b0; pix_data = '0;
  endtask

  task automatic send4(input logic [15:0] d, input logic l);
    int n = 0;
    p4_data = d; p4_valid = 1'b1; p4_last = l;
    @(negedge CLKI);
    while (!p4_ready && n < 200) begin
      @(negedge CLKI);
      n++;
    end
    if (!p4_ready) fail("pix4_accept_timeout");
    @(posedge CLKI);
    #1;
    p4_valid = 1'b0; p4_last = 1'b0; p4_data = '0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || sb4.size() != 0) && n < 500) begin
      @(negedge CLKI);
      n++;
    end
    check("drain_sb", 32'(sb.size()), 32'h0);
    check("drain_sb4", 32'(sb4.size()), 32'h0);
    repeat (3) @(posedge CLKI);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge CLKI);
    check("rst_pix_ready", 32'(pix_ready), 32'h0);
    check("rst_byte_valid", 32'(byte_valid), 32'h0);
    check("rst_byte_outs", 32'({byte_data, byte_keep, byte_last}), 32'h0);
    @(posedge CLKI); #1 RST = 1'b0;
    @(negedge CLKI);
    check("ready_after_rst", 32'(pix_ready), 32'h1);
    @(posedge CLKI); #1;

    // Two pixels, line length multiple of lanes
    expect2(32'h0201, 4'b0011, 1'b0);
    expect2(32'h0403, 4'b0011, 1'b0);
    expect2(32'h0605, 4'b0011, 1'b1);
    send(24'h030201, 1'b0);
    send(24'h060504, 1'b1);
    drain();

    // Single pixel line, partial final word
    expect2(32'h0201, 4'b0011, 1'b0);
    expect2(32'h0003, 4'b0001, 1'b1);
    send(24'h030201, 1'b1);
    drain();

    // Three pixel line (9 bytes)
    expect2(32'h0201, 4'b0011, 1'b0);
    expect2(32'h0403, 4'b0011, 1'b0);
    expect2(32'h0605, 4'b0011, 1'b0);
    expect2(32'h0807, 4'b0011, 1'b0);
    expect2(32'h0009, 4'b0001, 1'b1);
    send(24'h030201, 1'b0);
    send(24'h060504, 1'b0);
    send(24'h090807, 1'b1);
    drain();

    // Backpressure: 8 stalled cycles under a continuous 6-pixel stream (bytes 0x10..0x21)
    for (int j = 0; j < 9; j++)
      expect2({16'h0, 8'(8'h11 + 2*j), 8'(8'h10 + 2*j)}, 4'b0011, j == 8);
    byte_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send({8'(8'h12 + 3*i), 8'(8'h11 + 3*i), 8'(8'h10 + 3*i)}, i == 5);
      end
      begin
        int n = 0;
        @(negedge CLKI);
        while (!byte_valid && n < 50) begin
          @(negedge CLKI);
          n++;
        end
        if (!byte_valid) fail("stall_valid_timeout");
        repeat (8) begin
          @(negedge CLKI);
          check("stall_hold_data", 32'(byte_data), 32'h1110);
        end
        check("stall_hold_valid", 32'(byte_valid), 32'h1);
        check("stall_ready_low", 32'(pix_ready), 32'h0);
        @(posedge CLKI); #1 byte_ready = 1'b1;
      end
    join
    drain();

    // Reset after 1 of 3 pixels: nothing emitted, next line starts clean
    send(24'h0C0B0A, 1'b0);
    RST = 1'b1;
    @(negedge CLKI);
    check("midrst_valid_a", 32'(byte_valid), 32'h0);
    check("midrst_ready_a", 32'(pix_ready), 32'h0);
    @(posedge CLKI);
    @(negedge CLKI);
    check("midrst_valid_b", 32'(byte_valid), 32'h0);
    @(posedge CLKI); #1 RST = 1'b0;
    @(negedge CLKI);
    check("midrst_ready_after", 32'(pix_ready), 32'h1);
    check("midrst_valid_after", 32'(byte_valid), 32'h0);
    @(posedge CLKI); #1;
    expect2(32'h3231, 4'b0011, 1'b0);
    expect2(32'h3433, 4'b0011, 1'b0);
    expect2(32'h3635, 4'b0011, 1'b1);
    send(24'h333231, 1'b0);
    send(24'h363534, 1'b1);
    drain();

    // Four lanes, RGB565: two full words, last on the second
    sb4.push_back('{data: 32'h04030201, keep: 4'b1111, last: 1'b0});
    sb4.push_back('{data: 32'h08070605, keep: 4'b1111, last: 1'b1});
    send4(16'h0201, 1'b0);
    send4(16'h0403, 1'b0);
    send4(16'h0605, 1'b0);
    send4(16'h0807, 1'b1);
    drain();

`ifdef PIX2BYTE_WC_EN
    check("wc_pulses_all_seen", 32'(wc_exp.size()), 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pix2byte_gearbox.md
PIX2BYTE_GEARBOX -- requirements
Module: pix2byte_gearbox

Interface
REQ-001 SHALL have parameter NUM_LANES, default 2, meaning the number of output byte lanes; legal values are 1, 2 and 4.
REQ-002 SHALL have parameter PIX_WIDTH, default 24, meaning the pixel width in bits; legal values are 16 (RGB565) and 24 (RGB888).
REQ-003 SHALL derive constants BPP = PIX_WIDTH/8, meaning bytes per pixel, and CAP = 2*(BPP+NUM_LANES), meaning buffer capacity in bytes.
REQ-004 SHALL have one clock and a synchronous, active-high reset; CLKI is the clock and RST is the reset.
REQ-005 Ports, in order:
- CLKI  in  1  clock; all logic on its rising edge.
- RST  in  1  synchronous active-high reset.
- pix_data  in  PIX_WIDTH  pixel; byte 0 = bits [7:0].
- pix_valid  in  1  pixel valid.
- pix_last  in  1  last pixel of line; qualified by pix_valid.
- pix_ready  out  1  pixel accept.
- byte_data  out  8*NUM_LANES  output word; lane 0 = bits [7:0].
- byte_keep  out  NUM_LANES  per-lane valid mask.
- byte_valid  out  1  output word valid.
- byte_last  out  1  final word of line.
- byte_ready  in  1  downstream accept.

Function
REQ-006 A pixel SHALL be accepted on a cycle with pix_valid=1 and pix_ready=1; a word SHALL be transferred on a cycle with byte_valid=1 and byte_ready=1.
REQ-007 Accepted pixels SHALL be appended to a byte FIFO of depth CAP, byte 0 first; fill count cnt SHALL update as cnt + BPP*accept - popped.
REQ-008 pix_ready SHALL be 1 iff cnt <= CAP-BPP and no flush is pending; it SHALL be a function of registered state only, never of byte_ready.
REQ-009 byte_valid SHALL be 1 iff cnt >= NUM_LANES, or a flush is pending and cnt > 0.
REQ-010 Output lane k SHALL carry the k-th oldest FIFO byte; each transfer SHALL pop min(cnt, NUM_LANES) bytes.
REQ-011 Latency: a pixel accepted in cycle N SHALL make its bytes visible no earlier than cycle N+1; there SHALL be no combinational path from pix_* to byte_*.
REQ-012 Flush: accepting a pixel with pix_last=1 SHALL set flush pending; flush pending SHALL clear on the transfer that empties the FIFO.
REQ-013 The final word of a line SHALL assert byte_last=1; byte_keep SHALL have its low cnt bits set, and unused lanes SHALL be driven 0x00. Non-final words SHALL have byte_keep all ones and byte_last=0.
REQ-014 If the line length in bytes is a multiple of NUM_LANES, byte_last SHALL ride on the last full word; no empty word SHALL be emitted.
REQ-015 While byte_valid=1 and byte_ready=0, byte_data, byte_keep and byte_last SHALL hold stable.
REQ-016 Simultaneous accept and transfer in one cycle SHALL both take effect, with no byte lost or duplicated.
REQ-017 byte_valid=0 SHALL hold byte_data, byte_keep and byte_last at 0.

Reset
REQ-018 While RST=1: cnt=0, flush pending=0, pix_ready=0, byte_valid=0, byte_last=0, byte_keep=0, byte_data=0.
REQ-019 RST asserted mid-line SHALL discard all buffered bytes with no partial word emitted; pix_ready SHALL be 1 on the first cycle after RST deasserts.

Configuration
REQ-020 Macro PIX2BYTE_WC_EN defined: SHALL add outputs line_wc[15:0] and wc_valid; on the cycle after the byte_last transfer, wc_valid SHALL pulse for 1 cycle and line_wc SHALL hold the line byte count until the next pulse; reset value 0 for both.
REQ-021 Macro PIX2BYTE_WC_EN undefined: those ports and the counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-022 Defaults, byte_ready=1, pixels 0x030201 and 0x060504 (last on 2nd) -> words 0x0201, 0x0403, 0x0605; last word keep=11, byte_last=1.
REQ-023 Defaults, single pixel 0x030201 with last -> 0x0201 keep=11, then 0x0003 keep=01 byte_last=1.
REQ-024 Defaults, byte_ready=0 for 8 cycles with a continuous pixel stream -> pix_ready drops once cnt>7, byte_data stays stable, and the full byte sequence is intact after release.
REQ-025 NUM_LANES=4, PIX_WIDTH=16, 4 pixels 0x0201..0x0807 -> words 0x04030201 and 0x08070605 (last, keep=1111), with no extra word.
REQ-026 RST pulsed after 1 of 3 pixels of a line -> no byte_valid during or after; the next line's output starts with its own byte 0.
REQ-027 With PIX2BYTE_WC_EN, a 3-pixel RGB888 line -> wc_valid pulses once with line_wc=9.
